square_reconstruct: RTL and testbench
=====================================

// Module: square_reconstruct
// PURPOSE
//  Inverse of the SquareRoot block: takes a (result, residue) pair and rebuilds value = result*result + residue.
//  Sequential shift-add multiplier plus final add.
//  Sits downstream of SquareRoot as an in-system self-checker / decoder of its outputs.
// PARAMETERS
//  WORD_LENGTH  16  width of root and residue inputs; value output is 2*WORD_LENGTH
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-low; 0 clears all state immediately
//  start      in   1      request; sampled only while ready=1
//  root       in   WORD_LENGTH    square-root operand (SquareRoot result)
//  residue    in   WORD_LENGTH    remainder operand (SquareRoot residue)
//  ready      out  1      1 only in IDLE
//  done       out  1      one-cycle pulse when value is valid
//  value      out  2*WORD_LENGTH  root*root + residue; held until next completion
//  residue_err out 1      residue > 2*root (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset=0): state=IDLE, ready=1, done=0, value=0, residue_err=0, internal acc/counter/operand regs=0.
//  FSM IDLE -> MULT -> ADD -> DONE -> IDLE.
//  IDLE: if start=1 at edge E0, latch root/residue into operand regs, acc=0, cnt=0 -> MULT.
//   start=0 stays IDLE.
//  MULT: one multiplier bit per edge, LSB first.
//   If the current bit is set, acc += multiplicand << cnt.
//   cnt increments; after exactly WORD_LENGTH edges (E1..E_W) -> ADD.
//  ADD: at E_(W+1), value <= acc + residue_reg -> DONE.
//  DONE: done=1 for exactly this one cycle, then -> IDLE.
//  Latency: done high in the cycle following edge E_(W+1), i.e. W+2 cycles after start is accepted.
//  Throughput: one operation per W+3 cycles.
//  Width:
//   - acc and value are 2*WORD_LENGTH, unsigned.
//   - Max result (2^W-1)^2 + (2^W-1) < 2^(2W), so there is no overflow and no saturation logic.
//  Operands are latched at accept, so input changes while busy have no effect.
//  start while not IDLE is ignored, not queued; ready=0 throughout MULT/ADD/DONE.
//  start held high continuously re-triggers on each return to IDLE.
//  Reset mid-operation aborts immediately:
//   - no done pulse;
//   - value is cleared to 0.
//  root=0 or residue=0 are legal and need no special case.
// CONFIGURATION
//  Macro RESIDUE_CHECK_EN:
//   - defined: residue_err is registered in ADD, updated together with value.
//     It is set to (residue_reg > {root_reg,1'b0}) and held until the next completion.
//   - undefined: residue_err is constant 0; no comparator is built.
//  Port list is identical in both builds.
// STRUCTURE
//  Package square_root_pkg:
//   - state enum state_t {IDLE, MULT, ADD, DONE};
//   - localparam CNT_W = $clog2(WORD_LENGTH)+1 (derived in-module from the parameter);
//   - shared WORD_LENGTH default.
//  Sub-module shift_add_multiplier:
//   - holds acc, cnt and the per-bit step;
//   - control: load/step/last;
//   - the top keeps the FSM, the residue add and the optional check.
// TESTING
//  1. root=11, residue=6, start 1 cycle -> done after W+2 cycles, value=127 (round-trip of SquareRoot(127)).
//  2. root=0, residue=0 -> value=0, done pulses once, ready returns to 1 the following cycle.
//  3. root=16'hFFFF, residue=16'hFFFF -> value=32'hFFFF0000, no overflow.
//  4. start=1 again mid-MULT with root=3 -> ignored; first op completes with original value, single done pulse.
//  5. reset=0 at cycle 5 of MULT -> ready=1, value=0 immediately, no done.
//     A new start with root=2, residue=1 then gives value=5.
//  6. With RESIDUE_CHECK_EN: root=11, residue=23 -> residue_err=1; root=11, residue=22 -> residue_err=0.
//     Without the macro, residue_err is always 0.

Source files
------------

// File: rtl/square_reconstruct_pkg.sv
// Shared types for the square-root round-trip checker: FSM state encoding and default word length.
package square_root_pkg;
  localparam int WORD_LENGTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    ADD,
    DONE
  } state_t;
endpackage

// File: rtl/square_reconstruct_shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per step, LSB first, 2*WORD_LENGTH accumulator.
module shift_add_multiplier
  import square_root_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_load,
  input  logic                     i_step,
  input  logic [WORD_LENGTH-1:0]   i_mcand,
  input  logic [WORD_LENGTH-1:0]   i_mplier,
  output logic                     o_last,
  output logic [2*WORD_LENGTH-1:0] o_acc
);
  localparam int CNT_W = $clog2(WORD_LENGTH) + 1;

  logic [2*WORD_LENGTH-1:0] r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic [2*WORD_LENGTH-1:0] w_addend;

  assign w_addend = {{WORD_LENGTH{1'b0}}, i_mcand} << r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_step) begin
      if (i_mplier[r_cnt[CNT_W-2:0]]) r_acc <= r_acc + w_addend;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Asserted during the step that consumes the final multiplier bit
  assign o_last = (r_cnt == CNT_W'(WORD_LENGTH - 1));
  assign o_acc  = r_acc;
endmodule

// File: rtl/square_reconstruct.sv
// Rebuilds value = root*root + residue from a SquareRoot result pair.
// Optional residue range check is built only when RESIDUE_CHECK_EN is defined.
module square_reconstruct
  import square_root_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WORD_LENGTH-1:0]   root,
  input  logic [WORD_LENGTH-1:0]   residue,
  output logic                     ready,
  output logic                     done,
  output logic [2*WORD_LENGTH-1:0] value,
  output logic                     residue_err
);
  state_t r_state, w_next;
  logic [WORD_LENGTH-1:0]   r_root, r_residue;
  logic [2*WORD_LENGTH-1:0] r_value;
  logic [2*WORD_LENGTH-1:0] w_acc;
  logic w_load, w_step, w_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_load = 1'b1;
        w_next = MULT;
      end
      MULT: begin
        w_step = 1'b1;
        if (w_last) w_next = ADD;
      end
      ADD:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign ready = (r_state == IDLE);
  assign done  = (r_state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_root    <= '0;
      r_residue <= '0;
      r_value   <= '0;
    end else begin
      if (w_load) begin
        r_root    <= root;
        r_residue <= residue;
      end
      if (r_state == ADD) r_value <= w_acc + {{WORD_LENGTH{1'b0}}, r_residue};
    end
  end

  assign value = r_value;

  shift_add_multiplier #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_mcand (r_root),
    .i_mplier(r_root),
    .o_last  (w_last),
    .o_acc   (w_acc)
  );

`ifdef RESIDUE_CHECK_EN
  logic r_residue_err;

  // A valid square-root residue never exceeds 2*root
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_residue_err <= 1'b0;
    else if (r_state == ADD)   r_residue_err <= ({1'b0, r_residue} > {r_root, 1'b0});
  end

  assign residue_err = r_residue_err;
`else
  assign residue_err = 1'b0;
`endif
endmodule

// File: tb/tb_square_reconstruct.sv
// Scoreboard bench for square_reconstruct: directed cases plus random operands against an arithmetic model.
module tb_square_reconstruct;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   root = '0;
  logic [W-1:0]   residue = '0;
  logic           ready, done, residue_err;
  logic [2*W-1:0] value;

  typedef struct {
    logic [2*W-1:0] val;
    logic           err;
    int             cyc;
  } exp_t;

  exp_t           q[$];
  int             checks = 0;
  int             failures = 0;
  int             cyc = 0;
  logic [2*W-1:0] last_val = '0;
  logic           last_err = 1'b0;
  bit             chk_ready_next = 0;

  square_reconstruct #(.WORD_LENGTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .root       (root),
    .residue    (residue),
    .ready      (ready),
    .done       (done),
    .value      (value),
    .residue_err(residue_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic model_err(input logic [W-1:0] r, input logic [W-1:0] s);
`ifdef RESIDUE_CHECK_EN
    return (int'(s) > 2 * int'(r));
`else
    return 1'b0;
`endif
  endfunction

  task automatic issue(input logic [W-1:0] r, input logic [W-1:0] s);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 64'(ready), 64'd1);
      return;
    end
    start = 1'b1;
    root = r;
    residue = s;
    @(posedge clk);
    #1;
    e.val = 32'(r) * 32'(r) + 32'(s);
    e.err = model_err(r, s);
    e.cyc = cyc;
    q.push_back(e);
    start = 1'b0;
    root = W'($urandom);
    residue = W'($urandom);
  endtask

  // Monitor: pops expectations on done, otherwise checks held outputs
  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("value", 64'(value), 64'(e.val));
          check("residue_err", 64'(residue_err), 64'(e.err));
          check("latency", 64'(cyc), 64'(e.cyc + W + 1));
          check("ready_in_done", 64'(ready), 64'd0);
          last_val = e.val;
          last_err = e.err;
          chk_ready_next = 1;
        end
      end else begin
        check("value_hold", 64'(value), 64'(last_val));
        check("err_hold", 64'(residue_err), 64'(last_err));
        if (chk_ready_next) check("ready_after_done", 64'(ready), 64'd1);
        chk_ready_next = 0;
      end
    end
  end

  initial begin
    int n;
    #12;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_value", 64'(value), 64'd0);
    check("rst_err", 64'(residue_err), 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;

    issue(16'd11, 16'd6);
    issue(16'd0, 16'd0);
    issue(16'hFFFF, 16'hFFFF);

    // Start pulses while busy must be ignored
    issue(16'd100, 16'd5);
    repeat (4) @(negedge clk);
    start = 1'b1;
    root = 16'd3;
    residue = 16'd0;
    repeat (3) @(negedge clk);
    start = 1'b0;

    // Abort mid-MULT
    issue(16'd1234, 16'd77);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    q.delete();
    last_val = '0;
    last_err = 1'b0;
    chk_ready_next = 0;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_value", 64'(value), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_err", 64'(residue_err), 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    issue(16'd2, 16'd1);

    issue(16'd11, 16'd23);
    issue(16'd11, 16'd22);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] r, s;
      r = W'($urandom);
      s = (i % 3 == 0) ? W'($urandom_range(0, 2 * int'(r) < 65535 ? 2 * int'(r) : 65535)) : W'($urandom);
      issue(r, s);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
